regfile_ctrl: RTL and testbench

REGFILE_CTRL -- requirements
Module: regfile_ctrl

---
 rtl/regfile_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_regfile_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_ctrl.sv
// regfile_ctrl -- write-buffered front end for a 1R2/1W register file.
//
// Writes are queued in a DEPTH-entry in-order buffer and drained into the
// register file one per cycle. Two-port reads are issued directly when no
// buffered write targets either source register. The register file performs
// exactly one write or one two-port read per cycle and returns read data one
// cycle later. The response follows a read by exactly one cycle.
//
// Arbitration each cycle:
//   buffer full          -> drain head write
//   read pending & legal -> issue read
//   buffer nonempty      -> drain head write
//   otherwise            -> idle (all rf_* outputs 0)
//
// Optional feature (define the macro to enable):
//   REGFILE_CTRL_FWD_EN  reads that hit buffered writes issue without stalling
//                        and take the youngest matching buffered data per port.
//                        When undefined, such reads stall while the buffer drains.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_addr/wr_data  write request channel (addr 0 discarded)
//   rd_valid/rd_ready/rd_rs/rd_rt      read request channel (rd_ready = issued)
//   resp_valid/resp_rs_data/resp_rt_data  read response, one cycle after issue
//   rf_rw/rf_rs/rf_rt/rf_rd/rf_rd_data  register-file command
//   rf_rs_data/rf_rt_data              register-file registered read data
//   wb_count                           write-buffer occupancy
module regfile_ctrl #(
  parameter int DEPTH = 4,
  localparam int DATA_W = 8,
  localparam int ADDR_W = 3,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_rs,
  input  logic [ADDR_W-1:0] rd_rt,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rs_data,
  output logic [DATA_W-1:0] resp_rt_data,
  output logic              rf_rw,
  output logic [ADDR_W-1:0] rf_rs,
  output logic [ADDR_W-1:0] rf_rt,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_rd_data,
  input  logic [DATA_W-1:0] rf_rs_data,
  input  logic [DATA_W-1:0] rf_rt_data,
  output logic [CNT_W-1:0]  wb_count
);

`ifdef REGFILE_CTRL_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ISS_IDLE, ISS_WR, ISS_RD} issue_e;

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              rs_hit;
  logic              rt_hit;
  logic              rd_go;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;
  logic [PTR_W-1:0]  scan_idx;
  issue_e            issue;

  logic              vld_p1;
  logic              rs_byp_p1;
  logic              rt_byp_p1;
  logic [DATA_W-1:0] rs_byp_data_p1;
  logic [DATA_W-1:0] rt_byp_data_p1;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign wb_count = count;

  // Scan valid entries oldest to youngest; a later match overwrites an
  // earlier one, so the result is the youngest buffered write per port.
  // The head counts even when it is being drained this cycle.
  always_comb begin
    rs_hit   = 1'b0;
    rt_hit   = 1'b0;
    rs_fwd   = '0;
    rt_fwd   = '0;
    scan_idx = head;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PTR_W'(k);
      if (CNT_W'(k) < count) begin
        if ((rd_rs != '0) && (fifo_addr[scan_idx] == rd_rs)) begin
          rs_hit = 1'b1;
          rs_fwd = fifo_data[scan_idx];
        end
        if ((rd_rt != '0) && (fifo_addr[scan_idx] == rd_rt)) begin
          rt_hit = 1'b1;
          rt_fwd = fifo_data[scan_idx];
        end
      end
    end
  end

  assign rd_go = rd_valid && (FWD_EN || !(rs_hit || rt_hit));

  always_comb begin
    issue = ISS_IDLE;
    if (!reset) begin
      if (full)        issue = ISS_WR;
      else if (rd_go)  issue = ISS_RD;
      else if (!empty) issue = ISS_WR;
    end
  end

  always_comb begin
    rf_rw      = 1'b0;
    rf_rd      = '0;
    rf_rd_data = '0;
    rf_rs      = '0;
    rf_rt      = '0;
    rd_ready   = 1'b0;
    case (issue)
      ISS_WR: begin
        rf_rw      = 1'b1;
        rf_rd      = fifo_addr[head];
        rf_rd_data = fifo_data[head];
      end
      ISS_RD: begin
        rd_ready = 1'b1;
        rf_rs    = rd_rs;
        rf_rt    = rd_rt;
      end
      default: ;
    endcase
  end

  // No bypass into a full buffer: readiness depends only on start-of-cycle
  // occupancy, and is held low while reset is asserted.
  assign wr_ready = !reset && !full;
  assign push     = wr_valid && wr_ready && (wr_addr != '0);
  assign pop      = (issue == ISS_WR);

  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      vld_p1 <= (issue == ISS_RD);
    end
  end

  // ---- stage p0 -> p1: read issue to response ----
  // Address 0 and forwarded ports take their value from the bypass register
  // instead of the register file.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= wr_addr;
      fifo_data[tail] <= wr_data;
    end
    if (issue == ISS_RD) begin
      rs_byp_p1      <= (rd_rs == '0) || (FWD_EN && rs_hit);
      rt_byp_p1      <= (rd_rt == '0) || (FWD_EN && rt_hit);
      rs_byp_data_p1 <= FWD_EN ? rs_fwd : '0;
      rt_byp_data_p1 <= FWD_EN ? rt_fwd : '0;
    end
  end

  assign resp_valid   = vld_p1;
  assign resp_rs_data = !vld_p1 ? '0 : (rs_byp_p1 ? rs_byp_data_p1 : rf_rs_data);
  assign resp_rt_data = !vld_p1 ? '0 : (rt_byp_p1 ? rt_byp_data_p1 : rf_rt_data);

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl -- directed bench for regfile_ctrl with a behavioural
// register file, a queue-based reference model checked every cycle, and
// hand-computed literal expectations for the key scenarios.
module tb_regfile_ctrl;
  localparam int DEPTH = 4;
`ifdef REGFILE_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] rd_rs;
  logic [2:0] rd_rt;
  logic       resp_valid;
  logic [7:0] resp_rs_data;
  logic [7:0] resp_rt_data;
  logic       rf_rw;
  logic [2:0] rf_rs;
  logic [2:0] rf_rt;
  logic [2:0] rf_rd;
  logic [7:0] rf_rd_data;
  logic [7:0] rf_rs_data;
  logic [7:0] rf_rt_data;
  logic [2:0] wb_count;

  always #5 clk = ~clk;

  regfile_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_rs(rd_rs), .rd_rt(rd_rt),
    .resp_valid(resp_valid), .resp_rs_data(resp_rs_data), .resp_rt_data(resp_rt_data),
    .rf_rw(rf_rw), .rf_rs(rf_rs), .rf_rt(rf_rt), .rf_rd(rf_rd), .rf_rd_data(rf_rd_data),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .wb_count(wb_count)
  );

  // Register file: one write or one two-port registered read per cycle.
  // Entry 0 holds a nonzero value so a read of r0 must be zeroed by the DUT.
  logic [7:0] mem [0:7] = '{8'hEE, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
  always @(posedge clk) begin
    if (rf_rw) mem[rf_rd] <= rf_rd_data;
    else begin
      rf_rs_data <= mem[rf_rs];
      rf_rt_data <= mem[rf_rt];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  // Literal expectations posted by the stimulus for the current cycle.
  bit       p_wrr_en,  p_wrr;
  bit       p_rdr_en,  p_rdr;
  bit       p_cnt_en;
  int       p_cnt;
  bit       p_rfw_en,  p_rfw;
  bit [2:0] p_rfw_a;
  bit [7:0] p_rfw_d;
  bit       p_resp_en, p_resp_v;
  bit [7:0] p_resp_rs, p_resp_rt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue of pending writes, and arch[]
  // is the architectural register view (every write accepted so far). A
  // read must return arch[] as it stood before the cycle it issued in.
  typedef struct packed { logic [2:0] a; logic [7:0] d; } ent_t;
  ent_t     q[$];
  ent_t     e;
  bit [7:0] arch [0:7];
  bit       m_v = 1'b0;
  bit [7:0] m_rs, m_rt;
  bit       full, haz, do_rd, do_wr;

  always @(negedge clk) begin
    if (started) begin
      if (p_wrr_en) chk("pin_wr_ready", wr_ready, p_wrr);
      if (p_rdr_en) chk("pin_rd_ready", rd_ready, p_rdr);
      if (p_cnt_en) chk("pin_wb_count", wb_count, p_cnt);
      if (p_rfw_en) begin
        chk("pin_rf_rw", rf_rw, p_rfw);
        if (p_rfw) begin
          chk("pin_rf_rd", rf_rd, p_rfw_a);
          chk("pin_rf_rd_data", rf_rd_data, p_rfw_d);
        end
      end
      if (p_resp_en) begin
        chk("pin_resp_valid", resp_valid, p_resp_v);
        chk("pin_resp_rs_data", resp_rs_data, p_resp_rs);
        chk("pin_resp_rt_data", resp_rt_data, p_resp_rt);
      end

      chk("wb_count", wb_count, q.size());
      chk("resp_valid", resp_valid, m_v);
      if (m_v) begin
        chk("resp_rs_data", resp_rs_data, m_rs);
        chk("resp_rt_data", resp_rt_data, m_rt);
      end

      if (reset) begin
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);
        chk("rst_rf_rw", rf_rw, 0);
        chk("rst_rf_addr", {rf_rs, rf_rt, rf_rd}, 0);
        chk("rst_rf_rd_data", rf_rd_data, 0);
        q.delete();
        m_v = 1'b0;
        for (int i = 0; i < 8; i++) arch[i] = mem[i];
      end else begin
        full = (q.size() == DEPTH);
        haz  = 1'b0;
        foreach (q[i])
          if ((rd_rs != 0 && q[i].a == rd_rs) || (rd_rt != 0 && q[i].a == rd_rt)) haz = 1'b1;
        do_rd = !full && rd_valid && (FWD || !haz);
        do_wr = !do_rd && (q.size() > 0);

        chk("wr_ready", wr_ready, !full);
        chk("rd_ready", rd_ready, do_rd);
        chk("rf_rw", rf_rw, do_wr);
        if (do_wr) begin
          chk("rf_rd", rf_rd, q[0].a);
          chk("rf_rd_data", rf_rd_data, q[0].d);
        end
        if (do_rd) chk("rf_rs_rt", {rf_rs, rf_rt}, {rd_rs, rd_rt});
        if (!do_rd && !do_wr) chk("idle_rf", {rf_rs, rf_rt, rf_rd, rf_rd_data}, 0);

        m_v  = do_rd;
        m_rs = (rd_rs == 0) ? 8'h00 : arch[rd_rs];
        m_rt = (rd_rt == 0) ? 8'h00 : arch[rd_rt];
        if (do_wr) void'(q.pop_front());
        if (wr_valid && !full && wr_addr != 0) begin
          e.a = wr_addr;
          e.d = wr_data;
          q.push_back(e);
          arch[wr_addr] = wr_data;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    p_wrr_en = 0; p_rdr_en = 0; p_cnt_en = 0; p_rfw_en = 0; p_resp_en = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic rd(input logic [2:0] s, input logic [2:0] t);
    rd_valid = 1'b1; rd_rs = s; rd_rt = t;
  endtask

  task automatic pin_wrr(input bit v);  p_wrr_en = 1; p_wrr = v; endtask
  task automatic pin_rdr(input bit v);  p_rdr_en = 1; p_rdr = v; endtask
  task automatic pin_cnt(input int v);  p_cnt_en = 1; p_cnt = v; endtask
  task automatic pin_rfw(input bit v, input bit [2:0] a, input bit [7:0] d);
    p_rfw_en = 1; p_rfw = v; p_rfw_a = a; p_rfw_d = d;
  endtask
  task automatic pin_resp(input bit v, input bit [7:0] s, input bit [7:0] t);
    p_resp_en = 1; p_resp_v = v; p_resp_rs = s; p_resp_rt = t;
  endtask

  initial begin
    reset = 1'b1; wr_valid = 0; wr_addr = 0; wr_data = 0;
    rd_valid = 0; rd_rs = 0; rd_rt = 0;
    p_wrr_en = 0; p_rdr_en = 0; p_cnt_en = 0; p_rfw_en = 0; p_resp_en = 0;

    // Reset values, then ready in the first cycle with reset low
    step(); started = 1'b1;
    pin_wrr(0); pin_rdr(0); pin_cnt(0); pin_resp(0, 8'h00, 8'h00);
    step(); reset = 1'b0; pin_wrr(1);

    // Write r3, two idle cycles, then read rs=3/rt=0
    step(); wr(3'd3, 8'h5A); pin_wrr(1);
    step(); wr_valid = 0; pin_rfw(1, 3'd3, 8'h5A); pin_cnt(1);
    step();
    step(); rd(3'd3, 3'd0); pin_rdr(1); pin_cnt(0);
    step(); rd_valid = 0; pin_resp(1, 8'h5A, 8'h00);

    // Fill the buffer behind a continuously winning read
    step(); rd(3'd6, 3'd7); wr(3'd1, 8'h11); pin_rdr(1);
    step(); wr(3'd2, 8'h22);
    step(); wr(3'd3, 8'h33);
    step(); wr(3'd4, 8'h44); pin_cnt(3);
    step(); wr_valid = 0; pin_wrr(0); pin_cnt(4); pin_rdr(0); pin_rfw(1, 3'd1, 8'h11);
    step(); pin_cnt(3); pin_rdr(1); pin_wrr(1);
    step(); rd_valid = 0;
    repeat (4) step();

    // Read right behind a buffered write to the same register
    step(); wr(3'd5, 8'hA5);
    step(); wr_valid = 0; rd(3'd5, 3'd0);
    if (FWD) begin
      pin_rdr(1);
      step(); rd_valid = 0; pin_resp(1, 8'hA5, 8'h00); pin_rfw(1, 3'd5, 8'hA5);
      step();
    end else begin
      pin_rdr(0); pin_rfw(1, 3'd5, 8'hA5);
      step(); pin_rdr(1);
      step(); rd_valid = 0; pin_resp(1, 8'hA5, 8'h00);
    end
    step();

    // Two buffered writes to r2; the read must see the younger one
    step(); rd(3'd6, 3'd7); wr(3'd2, 8'h01);
    step(); wr(3'd2, 8'h02);
    step(); wr_valid = 0; rd(3'd2, 3'd0); pin_cnt(2);
    if (FWD) begin
      pin_rdr(1);
      step(); rd_valid = 0; pin_resp(1, 8'h02, 8'h00);
      repeat (3) step();
    end else begin
      pin_rdr(0); pin_rfw(1, 3'd2, 8'h01);
      step(); pin_rdr(0); pin_rfw(1, 3'd2, 8'h02);
      step(); pin_rdr(1); pin_cnt(0);
      step(); rd_valid = 0; pin_resp(1, 8'h02, 8'h00);
      step();
    end

    // Writes to r0 are dropped; reads of r0 return 0
    step(); wr(3'd0, 8'hFF); pin_wrr(1); pin_cnt(0);
    step(); wr_valid = 0; rd(3'd0, 3'd0); pin_cnt(0); pin_rfw(0, 3'd0, 8'h00); pin_rdr(1);
    step(); rd_valid = 0; pin_resp(1, 8'h00, 8'h00); pin_rfw(0, 3'd0, 8'h00);

    // Reset with three writes queued and a response in flight
    step(); rd(3'd6, 3'd7); wr(3'd1, 8'h91);
    step(); wr(3'd2, 8'h92);
    step(); wr(3'd3, 8'h93);
    step(); reset = 1'b1; wr_valid = 0; rd_valid = 0;
    pin_cnt(3); pin_wrr(0); pin_rdr(0);
    step(); reset = 1'b0; pin_resp(0, 8'h00, 8'h00); pin_cnt(0); pin_wrr(1);
    step(); rd(3'd1, 3'd2); pin_rdr(1);
    step(); rd(3'd3, 3'd0); pin_resp(1, 8'h11, 8'h02); pin_rdr(1);
    step(); rd_valid = 0; pin_resp(1, 8'h33, 8'h00);
    repeat (3) step();

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
